// File: rtl/fft_disp_pkg.sv
// fft_disp_pkg
// Shared definitions for the spectrum display path: default widths (also
// used by the renderer), the magnitude-unit latency, the saturating
// scale helper and the valid/eop tag that travels beside the data.
package fft_disp_pkg;

    localparam int DIN_W_DEF  = 17;
    localparam int DOUT_W_DEF = 9;
    localparam int SHIFT_DEF  = 7;
    localparam int IDX_W_DEF  = 10;

    // Sideband tag carried alongside each pipeline sample.
    typedef struct packed {
        logic vld;
        logic eop;
    } tag_t;

    // Abs stage + square stage + one stage per root bit + scale stage.
    function automatic int mag_latency(input int din_w);
        return din_w + 3;
    endfunction

    // v >> sh, clamped to all ones when it no longer fits in ow bits.
    function automatic logic [63:0] sat_shr(input logic [63:0] v, input int sh, input int ow);
        logic [63:0] s;
        s = v >> sh;
        if ((s >> ow) != 64'd0)
            return (64'd1 << ow) - 64'd1;
        return s;
    endfunction

endpackage

// File: rtl/fft_magnitude_norm_sqrt_pipe.sv
// sqrt_pipe
// Fully pipelined non-restoring integer square root, one root bit per
// register stage (RAD_W/2 stages). data_o = floor(sqrt(data_i)).
// Ports:
//   clk, rst_n        clock, async active-low reset (clears the tags only)
//   data_i  [RAD_W]   unsigned radicand
//   i_valid, i_eop    input tags
//   data_o  [RAD_W/2] root
//   o_valid, o_eop    tags aligned with data_o
module sqrt_pipe #(
    parameter int RAD_W = 34
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [RAD_W-1:0]     data_i,
    input  logic                 i_valid,
    input  logic                 i_eop,
    output logic [RAD_W/2-1:0]   data_o,
    output logic                 o_valid,
    output logic                 o_eop
);

    localparam int HALF = RAD_W / 2;
    // Signed partial remainder; headroom keeps the <<2 step from overflowing.
    localparam int RW   = HALF + 5;

    logic [RAD_W-1:0]       rad_d  [HALF];
    logic [RAD_W-1:0]       rad_q  [HALF];
    logic signed [RW-1:0]   rem_d  [HALF];
    logic signed [RW-1:0]   rem_q  [HALF];
    logic [HALF-1:0]        root_d [HALF];
    logic [HALF-1:0]        root_q [HALF];
    logic [HALF-1:0]        vld_pipe;
    logic [HALF-1:0]        eop_pipe;

    // Stage k consumes the next two radicand bits. A non-negative remainder
    // subtracts (4q+1), a negative one adds back (4q+3); the sign of the new
    // remainder is the next root bit, so no final correction is needed.
    always_comb begin
        logic [RAD_W-1:0]     r_in;
        logic signed [RW-1:0] m_in;
        logic signed [RW-1:0] sh;
        logic signed [RW-1:0] m_nx;
        logic [HALF-1:0]      q_in;
        for (int k = 0; k < HALF; k++) begin
            if (k == 0) begin
                r_in = data_i;
                m_in = '0;
                q_in = '0;
            end else begin
                r_in = rad_q[k-1];
                m_in = rem_q[k-1];
                q_in = root_q[k-1];
            end
            sh = {m_in[RW-3:0], r_in[RAD_W-1 -: 2]};
            if (!m_in[RW-1])
                m_nx = sh - {{(RW-HALF-2){1'b0}}, q_in, 2'b01};
            else
                m_nx = sh + {{(RW-HALF-2){1'b0}}, q_in, 2'b11};
            rad_d[k]  = r_in << 2;
            rem_d[k]  = m_nx;
            root_d[k] = {q_in[HALF-2:0], ~m_nx[RW-1]};
        end
    end

    // Datapath needs no reset: only the tags decide what is observed.
    always_ff @(posedge clk) begin
        for (int k = 0; k < HALF; k++) begin
            rad_q[k]  <= rad_d[k];
            rem_q[k]  <= rem_d[k];
            root_q[k] <= root_d[k];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe <= '0;
            eop_pipe <= '0;
        end else begin
            vld_pipe <= {vld_pipe[HALF-2:0], i_valid};
            eop_pipe <= {eop_pipe[HALF-2:0], i_eop};
        end
    end

    assign data_o  = root_q[HALF-1];
    assign o_valid = vld_pipe[HALF-1];
    assign o_eop   = eop_pipe[HALF-1];

endmodule

// File: rtl/fft_magnitude_norm.sv
// fft_magnitude_norm
// FFT-bin magnitude for the display path: |re|,|im| -> re^2+im^2 ->
// floor(sqrt) -> >>SHIFT with saturation to DOUT_W. Tracks per-frame peak.
// Latency DIN_W+3 clocks, one sample per clock, no backpressure.
// Ports:
//   clk, rst_n                     clock, async active-low reset
//   source_real/imag [DIN_W]       signed FFT bin
//   source_valid, source_eop       input qualifiers (eop needs valid)
//   data_modulus [DOUT_W]          scaled, saturated magnitude
//   data_valid, data_eop           output qualifiers
//   data_index [IDX_W]             bin index of the output sample
//   peak_value, peak_index         max of the last completed frame
//   peak_valid                     one-cycle pulse the clock after data_eop
module fft_magnitude_norm
    import fft_disp_pkg::*;
#(
    parameter int DIN_W  = DIN_W_DEF,
    parameter int DOUT_W = DOUT_W_DEF,
    parameter int SHIFT  = SHIFT_DEF,
    parameter int IDX_W  = IDX_W_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic signed [DIN_W-1:0]  source_real,
    input  logic signed [DIN_W-1:0]  source_imag,
    input  logic                     source_valid,
    input  logic                     source_eop,
    output logic [DOUT_W-1:0]        data_modulus,
    output logic                     data_valid,
    output logic                     data_eop,
    output logic [IDX_W-1:0]         data_index,
    output logic [DOUT_W-1:0]        peak_value,
    output logic [IDX_W-1:0]         peak_index,
    output logic                     peak_valid
);

    // Stage A: absolute values. Two's-complement negate of the most
    // negative input yields 2^(DIN_W-1), which is exact as unsigned.
    logic [DIN_W-1:0] abs_re_d, abs_im_d, abs_re_q, abs_im_q;
    tag_t             tag_a_q;

    assign abs_re_d = source_real[DIN_W-1] ? (~source_real) + 1'b1 : source_real;
    assign abs_im_d = source_imag[DIN_W-1] ? (~source_imag) + 1'b1 : source_imag;

    // Stage B: exact sum of squares.
    logic [2*DIN_W-1:0] sq_d, sq_q;
    tag_t               tag_b_q;

    assign sq_d = {{DIN_W{1'b0}}, abs_re_q} * {{DIN_W{1'b0}}, abs_re_q}
                + {{DIN_W{1'b0}}, abs_im_q} * {{DIN_W{1'b0}}, abs_im_q};

    // Root stages.
    logic [DIN_W-1:0] root;
    logic             root_vld, root_eop;

    sqrt_pipe #(.RAD_W(2*DIN_W)) u_sqrt (
        .clk     (clk),
        .rst_n   (rst_n),
        .data_i  (sq_q),
        .i_valid (tag_b_q.vld),
        .i_eop   (tag_b_q.eop),
        .data_o  (root),
        .o_valid (root_vld),
        .o_eop   (root_eop)
    );

    // Stage S: scale and saturate.
    logic [DOUT_W-1:0] mod_d, mod_q;
    logic              dvld_q, deop_q;

    assign mod_d = DOUT_W'(sat_shr(64'(root), SHIFT, DOUT_W));

    // Output-side index counter and peak tracker.
    logic [IDX_W-1:0]  idx_d, idx_q;
    logic [DOUT_W-1:0] max_d, max_q;
    logic [IDX_W-1:0]  max_idx_d, max_idx_q;
    logic [DOUT_W-1:0] peak_val_d, peak_val_q;
    logic [IDX_W-1:0]  peak_idx_d, peak_idx_q;
    logic              peak_vld_d, peak_vld_q;
    logic              take;
    logic [DOUT_W-1:0] cand_val;
    logic [IDX_W-1:0]  cand_idx;

    // Strict '>' keeps the earliest index on ties. The eop sample is folded
    // in before the result is published, and the tracker restarts at once so
    // a back-to-back frame starts clean.
    always_comb begin
        idx_d      = idx_q;
        max_d      = max_q;
        max_idx_d  = max_idx_q;
        peak_val_d = peak_val_q;
        peak_idx_d = peak_idx_q;
        peak_vld_d = 1'b0;
        take       = mod_q > max_q;
        cand_val   = take ? mod_q : max_q;
        cand_idx   = take ? idx_q : max_idx_q;
        if (dvld_q) begin
            if (deop_q) begin
                idx_d      = '0;
                max_d      = '0;
                max_idx_d  = '0;
                peak_val_d = cand_val;
                peak_idx_d = cand_idx;
                peak_vld_d = 1'b1;
            end else begin
                idx_d     = idx_q + 1'b1;
                max_d     = cand_val;
                max_idx_d = cand_idx;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            abs_re_q   <= '0;
            abs_im_q   <= '0;
            tag_a_q    <= '0;
            sq_q       <= '0;
            tag_b_q    <= '0;
            mod_q      <= '0;
            dvld_q     <= 1'b0;
            deop_q     <= 1'b0;
            idx_q      <= '0;
            max_q      <= '0;
            max_idx_q  <= '0;
            peak_val_q <= '0;
            peak_idx_q <= '0;
            peak_vld_q <= 1'b0;
        end else begin
            abs_re_q   <= abs_re_d;
            abs_im_q   <= abs_im_d;
            tag_a_q    <= '{vld: source_valid, eop: source_valid & source_eop};
            sq_q       <= sq_d;
            tag_b_q    <= tag_a_q;
            mod_q      <= mod_d;
            dvld_q     <= root_vld;
            deop_q     <= root_vld & root_eop;
            idx_q      <= idx_d;
            max_q      <= max_d;
            max_idx_q  <= max_idx_d;
            peak_val_q <= peak_val_d;
            peak_idx_q <= peak_idx_d;
            peak_vld_q <= peak_vld_d;
        end
    end

    assign data_modulus = mod_q;
    assign data_valid   = dvld_q;
    assign data_eop     = deop_q;
    assign data_index   = idx_q;
    assign peak_value   = peak_val_q;
    assign peak_index   = peak_idx_q;
    assign peak_valid   = peak_vld_q;

endmodule

// File: tb/tb_fft_magnitude_norm.sv
// Scoreboard bench for fft_magnitude_norm: directed vectors push expected
// outputs (value, index, eop, arrival cycle); negedge monitors pop/compare.
module tb_fft_magnitude_norm;
    import fft_disp_pkg::*;

    localparam int DW = 17;
    localparam int OW = 9;
    localparam int XW = 17;
    localparam int IW = 10;
    localparam int L  = mag_latency(DW);

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    // Default-parameter DUT.
    logic signed [DW-1:0] s_re = '0, s_im = '0;
    logic s_vld = 1'b0, s_eop = 1'b0;
    logic [OW-1:0] data_modulus, peak_value;
    logic data_valid, data_eop, peak_valid;
    logic [IW-1:0] data_index, peak_index;

    // Exact-root DUT: SHIFT=0, DOUT_W=17.
    logic signed [DW-1:0] x_re = '0, x_im = '0;
    logic x_vld = 1'b0, x_eop = 1'b0;
    logic [XW-1:0] x_mod, x_pval;
    logic x_dvld, x_deop, x_pvld;
    logic [IW-1:0] x_idx, x_pidx;

    fft_magnitude_norm #(.DIN_W(DW), .DOUT_W(OW), .SHIFT(7), .IDX_W(IW)) dut (
        .clk(clk), .rst_n(rst_n),
        .source_real(s_re), .source_imag(s_im),
        .source_valid(s_vld), .source_eop(s_eop),
        .data_modulus(data_modulus), .data_valid(data_valid), .data_eop(data_eop),
        .data_index(data_index), .peak_value(peak_value), .peak_index(peak_index),
        .peak_valid(peak_valid)
    );

    fft_magnitude_norm #(.DIN_W(DW), .DOUT_W(XW), .SHIFT(0), .IDX_W(IW)) dut_x (
        .clk(clk), .rst_n(rst_n),
        .source_real(x_re), .source_imag(x_im),
        .source_valid(x_vld), .source_eop(x_eop),
        .data_modulus(x_mod), .data_valid(x_dvld), .data_eop(x_deop),
        .data_index(x_idx), .peak_value(x_pval), .peak_index(x_pidx),
        .peak_valid(x_pvld)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int mod;
        int idx;
        bit eop;
        int cyc;
    } exp_t;

    exp_t q[$];
    exp_t qx[$];
    exp_t pq[$];
    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string nm, input int act, input int want);
        n_chk++;
        if (act != want) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cyc %0d)", nm, act, want, cyc);
        end
    endtask

    task automatic send(input int re, input int im, input bit eop, input bit push,
                        input int emod, input int eidx);
        @(posedge clk); #1;
        s_re = re[DW-1:0];
        s_im = im[DW-1:0];
        s_vld = 1'b1;
        s_eop = eop;
        if (push) q.push_back('{emod, eidx, eop, cyc + L});
    endtask

    task automatic sendx(input int re, input int im, input int emod, input int eidx);
        @(posedge clk); #1;
        x_re = re[DW-1:0];
        x_im = im[DW-1:0];
        x_vld = 1'b1;
        x_eop = 1'b0;
        qx.push_back('{emod, eidx, 1'b0, cyc + L});
    endtask

    // Call in the same timestep as the eop send.
    task automatic exp_pk(input int v, input int i);
        pq.push_back('{v, i, 1'b0, cyc + L + 1});
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            s_vld = 1'b0; s_eop = 1'b0;
            x_vld = 1'b0; x_eop = 1'b0;
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && (q.size() + qx.size() + pq.size()) > 0; i++)
            @(negedge clk);
    endtask

    // Monitors: every cycle where an output is expected or present counts.
    bit ev, evx, evp;

    always @(negedge clk) begin
        ev = (q.size() > 0) && (q[0].cyc == cyc);
        if (ev || data_valid || data_eop) begin
            n_chk++;
            if (ev && data_valid) begin
                if (data_modulus != q[0].mod || data_index != q[0].idx || data_eop != q[0].eop) begin
                    n_err++;
                    $display("FAIL out: got mod=%0d idx=%0d eop=%0b, expected mod=%0d idx=%0d eop=%0b (cyc %0d)",
                             data_modulus, data_index, data_eop, q[0].mod, q[0].idx, q[0].eop, cyc);
                end
                void'(q.pop_front());
            end else begin
                n_err++;
                $display("FAIL out_valid: got valid=%0b eop=%0b, expected valid=%0b (cyc %0d)",
                         data_valid, data_eop, ev, cyc);
                if (ev) void'(q.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        evx = (qx.size() > 0) && (qx[0].cyc == cyc);
        if (evx || x_dvld) begin
            n_chk++;
            if (evx && x_dvld) begin
                if (x_mod != qx[0].mod || x_idx != qx[0].idx) begin
                    n_err++;
                    $display("FAIL exact: got mod=%0d idx=%0d, expected mod=%0d idx=%0d (cyc %0d)",
                             x_mod, x_idx, qx[0].mod, qx[0].idx, cyc);
                end
                void'(qx.pop_front());
            end else begin
                n_err++;
                $display("FAIL exact_valid: got valid=%0b, expected valid=%0b (cyc %0d)", x_dvld, evx, cyc);
                if (evx) void'(qx.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        evp = (pq.size() > 0) && (pq[0].cyc == cyc);
        if (evp || peak_valid) begin
            n_chk++;
            if (evp && peak_valid) begin
                if (peak_value != pq[0].mod || peak_index != pq[0].idx) begin
                    n_err++;
                    $display("FAIL peak: got value=%0d index=%0d, expected value=%0d index=%0d (cyc %0d)",
                             peak_value, peak_index, pq[0].mod, pq[0].idx, cyc);
                end
                void'(pq.pop_front());
            end else begin
                n_err++;
                $display("FAIL peak_valid: got %0b, expected %0b (cyc %0d)", peak_valid, evp, cyc);
                if (evp) void'(pq.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (cyc %0d)", cyc);
        $fatal(1);
    end

    initial begin
        // Reset state.
        repeat (3) @(negedge clk);
        chk("rst_modulus",   int'(data_modulus), 0);
        chk("rst_valid",     int'(data_valid),   0);
        chk("rst_eop",       int'(data_eop),     0);
        chk("rst_index",     int'(data_index),   0);
        chk("rst_peak_val",  int'(peak_value),   0);
        chk("rst_peak_idx",  int'(peak_index),   0);
        chk("rst_peak_vld",  int'(peak_valid),   0);
        chk("rst_x_valid",   int'(x_dvld),       0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle(2);

        // Exact root, including floor cases; gaps keep outputs one cycle wide.
        sendx(3, -4, 5, 0);
        idle(2);
        sendx(-65536, -65536, 92681, 1);
        idle(1);
        sendx(65535, 65535, 92680, 2);
        sendx(1, 1, 1, 3);
        idle(1);

        // Saturation and scaling.
        send(-65536, -65536, 1'b0, 1'b1, 511, 0);
        send(12800, 0, 1'b0, 1'b1, 100, 1);
        send(0, -127, 1'b1, 1'b1, 0, 2);
        exp_pk(511, 0);
        idle(1);

        // Valid gaps 1,0,0,1,1.
        send(768, 1024, 1'b0, 1'b1, 10, 0);
        idle(2);
        send(1536, -2048, 1'b0, 1'b1, 20, 1);
        send(-2304, 3072, 1'b1, 1'b1, 30, 2);
        exp_pk(30, 2);
        idle(1);

        // Peak with ties: 3,9,1,4,9,9,2,7.
        send(384, 0, 1'b0, 1'b1, 3, 0);
        send(0, -1152, 1'b0, 1'b1, 9, 1);
        send(-128, 0, 1'b0, 1'b1, 1, 2);
        send(0, 512, 1'b0, 1'b1, 4, 3);
        send(1152, 0, 1'b0, 1'b1, 9, 4);
        send(1200, 0, 1'b0, 1'b1, 9, 5);
        send(0, 300, 1'b0, 1'b1, 2, 6);
        send(-900, 0, 1'b1, 1'b1, 7, 7);
        exp_pk(9, 1);
        idle(3);

        // Back-to-back frames.
        send(256, 0, 1'b0, 1'b1, 2, 0);
        send(1280, 0, 1'b0, 1'b1, 10, 1);
        send(640, 0, 1'b0, 1'b1, 5, 2);
        send(0, -768, 1'b1, 1'b1, 6, 3);
        exp_pk(10, 1);
        send(1024, 0, 1'b0, 1'b1, 8, 0);
        send(0, 1024, 1'b0, 1'b1, 8, 1);
        send(-1536, 0, 1'b0, 1'b1, 12, 2);
        send(0, -1408, 1'b1, 1'b1, 11, 3);
        exp_pk(12, 2);
        idle(1);
        drain();

        // Reset with 10 samples in flight: all must vanish.
        for (int i = 0; i < 10; i++)
            send(1000 + 100 * i, 0, 1'b0, 1'b0, 0, 0);
        @(posedge clk); #1;
        s_vld = 1'b0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (25) begin
            @(negedge clk);
            chk("post_rst_valid", int'(data_valid), 0);
        end
        chk("post_rst_index", int'(data_index), 0);
        send(1280, 0, 1'b1, 1'b1, 10, 0);
        exp_pk(10, 0);
        idle(1);
        drain();

        chk("pending_expectations", q.size() + qx.size() + pq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end

endmodule
